// File: rtl/tcount_sched.sv
// Round-robin scheduler sharing one up-counter between two timed-interval requesters.
// Optional SCHED_ABORT_EN: a dropped request during CLEAR/RUN aborts the grant without done.
module tcount_sched #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [1:0]       i_req,
  input  logic [WIDTH-1:0] i_len0,
  input  logic [WIDTH-1:0] i_len1,
  input  logic [WIDTH-1:0] i_cnt_q,
  output logic             o_cnt_en,
  output logic             o_cnt_clr,
  output logic [1:0]       o_gnt,
  output logic [1:0]       o_done,
  output logic             o_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [WIDTH-1:0] r_len;
  logic [WIDTH-1:0] w_len_nxt;
  logic [1:0]       r_gnt;
  logic [1:0]       w_gnt_nxt;
  logic [1:0]       r_done;
  logic [1:0]       w_done_nxt;
  logic             r_clr;
  logic             w_clr_nxt;
  logic             w_win;
  logic             w_at_len;
  logic             w_abort;

  assign w_at_len  = (i_cnt_q == r_len);
  assign o_cnt_en  = (r_state == S_RUN) && !w_at_len;
  assign o_cnt_clr = r_clr;
  assign o_gnt     = r_gnt;
  assign o_done    = r_done;
  assign o_busy    = (r_state != S_IDLE);

  // Round-robin pick: a tie goes to the requester that did not win last time
  always_comb begin
    w_win = 1'b0;
    case (i_req)
      2'b01:   w_win = 1'b0;
      2'b10:   w_win = 1'b1;
      2'b11:   w_win = ~r_last;
      default: w_win = 1'b0;
    endcase
  end

  // r_last always names the current owner while a grant is active
  always_comb begin
`ifdef SCHED_ABORT_EN
    w_abort = ~i_req[r_last];
`else
    w_abort = 1'b0;
`endif
  end

  // Next-state and registered-output decode
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_len_nxt   = r_len;
    w_gnt_nxt   = r_gnt;
    w_done_nxt  = 2'b00;
    w_clr_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|i_req) begin
          w_state_nxt = S_CLEAR;
          w_last_nxt  = w_win;
          w_len_nxt   = w_win ? i_len1 : i_len0;
          w_gnt_nxt   = w_win ? 2'b10 : 2'b01;
          w_clr_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
        end else if (w_at_len) begin
          w_state_nxt = S_DONE;
          w_done_nxt  = r_gnt;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_len   <= {WIDTH{1'b0}};
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_clr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_len   <= w_len_nxt;
      r_gnt   <= w_gnt_nxt;
      r_done  <= w_done_nxt;
      r_clr   <= w_clr_nxt;
    end
  end

endmodule
